// File: rtl/unidade_load_store_pkg.sv
// Shared definitions for the load/store unit: state encodings, access sizes, default width.
// Combinational helpers only; no latency. No flow control.
// Optional alignment checking is controlled by VERIFICA_ALINHAMENTO_EN in the top.
package unidade_load_store_pkg;

  localparam int LARGURA_PADRAO = 32;

  localparam logic [1:0] TAM_BYTE    = 2'b00;
  localparam logic [1:0] TAM_MEIA    = 2'b01;
  localparam logic [1:0] TAM_PALAVRA = 2'b10;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    LER      = 3'd1,
    DADO     = 3'd2,
    MESCLA   = 3'd3,
    ESCREVER = 3'd4,
    FIM      = 3'd5
  } estado_t;

  // Clears the offset bits below the access size so lanes always start on a natural boundary.
  function automatic logic [1:0] alinha_desloc(input logic [1:0] tam, input logic [1:0] desloc);
    logic [1:0] r;
    r = 2'b00;
    case (tam)
      TAM_BYTE: r = desloc;
      TAM_MEIA: r = {desloc[1], 1'b0};
      default:  r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/unidade_load_store_alinha_dados.sv
// Lane extraction with sign/zero extension for loads, and lane merge for partial stores.
// Purely combinational, zero latency. No flow control.
module alinha_dados
  import unidade_load_store_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic [1:0]         tamanho,
  input  logic [1:0]         deslocamento,
  input  logic               comSinal,
  input  logic [LARGURA-1:0] palavra,
  input  logic [LARGURA-1:0] dadoStore,
  output logic [LARGURA-1:0] dadoExtraido,
  output logic [LARGURA-1:0] palavraMesclada
);

  logic [7:0]  byte_sel;
  logic [15:0] meia_sel;
  logic [4:0]  base_byte;
  logic [4:0]  base_meia;

  always_comb begin
    base_byte       = {deslocamento, 3'b000};
    base_meia       = {deslocamento[1], 4'b0000};
    byte_sel        = palavra[base_byte +: 8];
    meia_sel        = palavra[base_meia +: 16];
    dadoExtraido    = palavra;
    palavraMesclada = palavra;
    case (tamanho)
      TAM_BYTE: begin
        dadoExtraido                   = {{(LARGURA-8){comSinal & byte_sel[7]}}, byte_sel};
        palavraMesclada[base_byte +: 8] = dadoStore[7:0];
      end
      TAM_MEIA: begin
        dadoExtraido                    = {{(LARGURA-16){comSinal & meia_sel[15]}}, meia_sel};
        palavraMesclada[base_meia +: 16] = dadoStore[15:0];
      end
      TAM_PALAVRA: begin
        dadoExtraido    = palavra;
        palavraMesclada = dadoStore;
      end
      default: begin
        dadoExtraido    = palavra;
        palavraMesclada = palavra;
      end
    endcase
  end

endmodule

// File: rtl/unidade_load_store.sv
// Load/store controller in front of a word memory (registered read, negedge write); RMW for byte/half stores.
// Latency: load 3 cycles, word store 2, byte/half store 4, fault 1 (pronto pulse in FIM).
// One request at a time; iniciar is ignored while ocupado. VERIFICA_ALINHAMENTO_EN enables alignment faults.
module unidade_load_store
  import unidade_load_store_pkg::*;
#(
  parameter int LARGURA  = LARGURA_PADRAO,
  parameter int PALAVRAS = 1600
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               escrever,
  input  logic [1:0]         tamanho,
  input  logic               comSinal,
  input  logic [LARGURA-1:0] endereco,
  input  logic [LARGURA-1:0] dadoStore,
  output logic               memRead,
  output logic               memWrite,
  output logic [LARGURA-1:0] enderecoMem,
  output logic [LARGURA-1:0] dadoEscrita,
  input  logic [LARGURA-1:0] dadoLido,
  output logic               ocupado,
  output logic               pronto,
  output logic [LARGURA-1:0] dadoLoad,
  output logic               erro
);

  localparam logic [LARGURA-1:0] PALAVRAS_W = LARGURA'(PALAVRAS);

  estado_t estado, prox;

  logic               req_escrever;
  logic [1:0]         req_tamanho;
  logic               req_comSinal;
  logic [1:0]         req_desloc;
  logic [LARGURA-1:0] req_dadoStore;
  logic               falha;

  logic [LARGURA-1:0] indice;
  logic               fora_faixa;
  logic               reservado;
  logic               desalinhado;
  logic               falha_nova;
  logic               aceita;
  logic [LARGURA-1:0] dado_extraido;
  logic [LARGURA-1:0] palavra_mesclada;

  assign indice     = {2'b00, endereco[LARGURA-1:2]};
  assign fora_faixa = (indice >= PALAVRAS_W);
  assign reservado  = (tamanho == 2'b11);

`ifdef VERIFICA_ALINHAMENTO_EN
  assign desalinhado = ((tamanho == TAM_MEIA) && endereco[0]) ||
                       ((tamanho == TAM_PALAVRA) && (endereco[1:0] != 2'b00));
`else
  assign desalinhado = 1'b0;
`endif

  assign falha_nova = fora_faixa | reservado | desalinhado;

  // FIM counts as idle so a request arriving in the pronto cycle is taken without a bubble.
  assign ocupado = (estado != OCIOSO) && (estado != FIM);
  assign aceita  = iniciar && !ocupado;

  assign memRead  = (estado == LER);
  assign memWrite = (estado == ESCREVER);
  assign pronto   = (estado == FIM);
  assign erro     = (estado == FIM) && falha;

  alinha_dados #(.LARGURA(LARGURA)) u_alinha (
    .tamanho         (req_tamanho),
    .deslocamento    (req_desloc),
    .comSinal        (req_comSinal),
    .palavra         (dadoLido),
    .dadoStore       (req_dadoStore),
    .dadoExtraido    (dado_extraido),
    .palavraMesclada (palavra_mesclada)
  );

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO, FIM: begin
        prox = OCIOSO;
        if (aceita) begin
          if (falha_nova)
            prox = FIM;
          else if (escrever && (tamanho == TAM_PALAVRA))
            prox = ESCREVER;
          else
            prox = LER;
        end
      end
      LER:      prox = req_escrever ? MESCLA : DADO;
      DADO:     prox = FIM;
      MESCLA:   prox = ESCREVER;
      ESCREVER: prox = FIM;
      default:  prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado        <= OCIOSO;
      req_escrever  <= 1'b0;
      req_tamanho   <= TAM_BYTE;
      req_comSinal  <= 1'b0;
      req_desloc    <= 2'b00;
      req_dadoStore <= '0;
      falha         <= 1'b0;
      dadoLoad      <= '0;
      enderecoMem   <= '0;
      dadoEscrita   <= '0;
    end else begin
      estado <= prox;
      if (aceita) begin
        req_escrever  <= escrever;
        req_tamanho   <= tamanho;
        req_comSinal  <= comSinal;
        req_desloc    <= alinha_desloc(tamanho, endereco[1:0]);
        req_dadoStore <= dadoStore;
        falha         <= falha_nova;
        if (!falha_nova) begin
          enderecoMem <= indice;
          if (escrever && (tamanho == TAM_PALAVRA))
            dadoEscrita <= dadoStore;
        end
      end
      if (estado == DADO)
        dadoLoad <= dado_extraido;
      if (estado == MESCLA)
        dadoEscrita <= palavra_mesclada;
    end
  end

endmodule

// File: tb/tb_unidade_load_store.sv
// Directed bench for unidade_load_store with a behavioural word memory (registered read, negedge write).
module tb_unidade_load_store;

  logic        clock = 1'b0;
  logic        reset;
  logic        iniciar;
  logic        escrever;
  logic [1:0]  tamanho;
  logic        comSinal;
  logic [31:0] endereco;
  logic [31:0] dadoStore;
  logic        memRead;
  logic        memWrite;
  logic [31:0] enderecoMem;
  logic [31:0] dadoEscrita;
  logic [31:0] dadoLido;
  logic        ocupado;
  logic        pronto;
  logic [31:0] dadoLoad;
  logic        erro;

  logic [31:0] mem [0:1599];
  logic        pre_en;
  logic [10:0] pre_idx;
  logic [31:0] pre_val;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  unidade_load_store #(.LARGURA(32), .PALAVRAS(1600)) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .escrever    (escrever),
    .tamanho     (tamanho),
    .comSinal    (comSinal),
    .endereco    (endereco),
    .dadoStore   (dadoStore),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .enderecoMem (enderecoMem),
    .dadoEscrita (dadoEscrita),
    .dadoLido    (dadoLido),
    .ocupado     (ocupado),
    .pronto      (pronto),
    .dadoLoad    (dadoLoad),
    .erro        (erro)
  );

  always @(posedge clock)
    if (memRead && enderecoMem < 32'd1600)
      dadoLido <= mem[enderecoMem[10:0]];

  always @(negedge clock) begin
    if (pre_en)
      mem[pre_idx] <= pre_val;
    else if (memWrite && enderecoMem < 32'd1600)
      mem[enderecoMem[10:0]] <= dadoEscrita;
  end

  // Issues one request, then watches up to 12 cycles for pronto, counting strobes seen on the way.
  task automatic requisitar(input logic we, input logic [1:0] tam, input logic sinal,
                            input logic [31:0] ender, input logic [31:0] dado,
                            output int ciclos, output logic err, output int nrd,
                            output int nwr, output logic [31:0] wdat);
    ciclos = -1; err = 1'bx; nrd = 0; nwr = 0; wdat = 32'hx;
    @(negedge clock);
    escrever = we; tamanho = tam; comSinal = sinal; endereco = ender; dadoStore = dado;
    iniciar = 1'b1;
    @(posedge clock);
    #1 iniciar = 1'b0;
    endereco = 32'hFFFF_FFFF; dadoStore = 32'h5A5A_5A5A; tamanho = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (memRead) nrd++;
      if (memWrite) begin nwr++; wdat = dadoEscrita; end
      if (pronto) begin
        ciclos = c; err = erro;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; iniciar = 1'b0; escrever = 1'b0; tamanho = 2'b00; comSinal = 1'b0;
    endereco = '0; dadoStore = '0;
    pre_en = 1'b1; pre_idx = 11'd5; pre_val = 32'h8899_AABB;
    repeat (3) @(posedge clock);
    @(negedge clock);
    pre_en = 1'b0;
    checks++;
    if ({ocupado, pronto, erro, memRead, memWrite} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {ocupado, pronto, erro, memRead, memWrite});
    end
    checks++;
    if (dadoLoad !== 32'h0 || enderecoMem !== 32'h0 || dadoEscrita !== 32'h0) begin
      errors++; $display("FAIL reset_regs got load=%h addr=%h wr=%h want zeros", dadoLoad, enderecoMem, dadoEscrita);
    end
    reset = 1'b0;
  endtask

  task automatic test_load_byte;
    int ciclos, nrd, nwr; logic err; logic [31:0] w;
    requisitar(1'b0, 2'b00, 1'b1, 32'h15, 32'h0, ciclos, err, nrd, nwr, w);
    checks++;
    if (ciclos !== 3 || nrd !== 1 || nwr !== 0 || err !== 1'b0) begin
      errors++; $display("FAIL load_byte_timing got cyc=%0d rd=%0d wr=%0d err=%b want 3 1 0 0", ciclos, nrd, nwr, err);
    end
    checks++;
    if (dadoLoad !== 32'hFFFF_FFAA) begin
      errors++; $display("FAIL load_byte_data got %h want FFFFFFAA", dadoLoad);
    end
    @(negedge clock);
    checks++;
    if (pronto !== 1'b0) begin
      errors++; $display("FAIL pronto_pulse got %b want 0", pronto);
    end
  endtask

  task automatic test_load_half;
    int ciclos, nrd, nwr; logic err; logic [31:0] w;
    requisitar(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, ciclos, err, nrd, nwr, w);
    checks++;
    if (ciclos !== 3 || err !== 1'b0 || dadoLoad !== 32'h0000_8899) begin
      errors++; $display("FAIL load_half got cyc=%0d err=%b data=%h want 3 0 00008899", ciclos, err, dadoLoad);
    end
  endtask

  task automatic test_store_byte;
    int ciclos, nrd, nwr; logic err; logic [31:0] w;
    requisitar(1'b1, 2'b00, 1'b0, 32'h14, 32'hABCD_EF12, ciclos, err, nrd, nwr, w);
    checks++;
    if (ciclos !== 4 || nrd !== 1 || nwr !== 1 || err !== 1'b0) begin
      errors++; $display("FAIL store_byte_timing got cyc=%0d rd=%0d wr=%0d err=%b want 4 1 1 0", ciclos, nrd, nwr, err);
    end
    checks++;
    if (w !== 32'h8899_AA12) begin
      errors++; $display("FAIL store_byte_merge got %h want 8899AA12", w);
    end
    requisitar(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, ciclos, err, nrd, nwr, w);
    checks++;
    if (ciclos !== 3 || dadoLoad !== 32'h8899_AA12) begin
      errors++; $display("FAIL store_byte_readback got cyc=%0d data=%h want 3 8899AA12", ciclos, dadoLoad);
    end
  endtask

  task automatic test_store_word;
    int ciclos, nrd, nwr; logic err; logic [31:0] w;
    requisitar(1'b1, 2'b10, 1'b0, 32'h18, 32'hDEAD_BEEF, ciclos, err, nrd, nwr, w);
    checks++;
    if (ciclos !== 2 || nrd !== 0 || nwr !== 1 || w !== 32'hDEAD_BEEF || err !== 1'b0) begin
      errors++; $display("FAIL store_word got cyc=%0d rd=%0d wr=%0d data=%h err=%b want 2 0 1 DEADBEEF 0",
                         ciclos, nrd, nwr, w, err);
    end
    requisitar(1'b0, 2'b10, 1'b1, 32'h18, 32'h0, ciclos, err, nrd, nwr, w);
    checks++;
    if (dadoLoad !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL store_word_readback got %h want DEADBEEF", dadoLoad);
    end
  endtask

  task automatic test_faults;
    int ciclos, nrd, nwr; logic err; logic [31:0] w;
    requisitar(1'b0, 2'b10, 1'b0, 32'h1900, 32'h0, ciclos, err, nrd, nwr, w);
    checks++;
    if (ciclos !== 1 || err !== 1'b1 || nrd !== 0 || nwr !== 0 || dadoLoad !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL fault_range got cyc=%0d err=%b rd=%0d wr=%0d load=%h want 1 1 0 0 DEADBEEF",
                         ciclos, err, nrd, nwr, dadoLoad);
    end
    requisitar(1'b1, 2'b11, 1'b0, 32'h14, 32'h1234_5678, ciclos, err, nrd, nwr, w);
    checks++;
    if (ciclos !== 1 || err !== 1'b1 || nrd !== 0 || nwr !== 0) begin
      errors++; $display("FAIL fault_reserved got cyc=%0d err=%b rd=%0d wr=%0d want 1 1 0 0", ciclos, err, nrd, nwr);
    end
    requisitar(1'b1, 2'b10, 1'b0, 32'h18FC, 32'h1111_2222, ciclos, err, nrd, nwr, w);
    checks++;
    if (ciclos !== 2 || err !== 1'b0 || nwr !== 1) begin
      errors++; $display("FAIL last_word got cyc=%0d err=%b wr=%0d want 2 0 1", ciclos, err, nwr);
    end
  endtask

  task automatic test_alinhamento;
    int ciclos, nrd, nwr; logic err; logic [31:0] w;
    requisitar(1'b0, 2'b01, 1'b0, 32'h15, 32'h0, ciclos, err, nrd, nwr, w);
    checks++;
`ifdef VERIFICA_ALINHAMENTO_EN
    if (ciclos !== 1 || err !== 1'b1 || nrd !== 0 || nwr !== 0) begin
      errors++; $display("FAIL misaligned_half got cyc=%0d err=%b rd=%0d wr=%0d want 1 1 0 0", ciclos, err, nrd, nwr);
    end
`else
    if (ciclos !== 3 || err !== 1'b0 || dadoLoad !== 32'h0000_AA12) begin
      errors++; $display("FAIL misaligned_half got cyc=%0d err=%b data=%h want 3 0 0000AA12", ciclos, err, dadoLoad);
    end
`endif
  endtask

  task automatic test_concorrencia;
    logic [3:0] rd, oc, pr;
    int fim2;
    fim2 = -1;
    @(negedge clock);
    escrever = 1'b0; tamanho = 2'b00; comSinal = 1'b1; endereco = 32'h15; iniciar = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      rd[c] = memRead; oc[c] = ocupado; pr[c] = pronto;
    end
    checks++;
    if (rd[1] !== 1'b1 || rd[2] !== 1'b0 || rd[3] !== 1'b0 || oc[2] !== 1'b1) begin
      errors++; $display("FAIL held_iniciar_busy got rd=%b%b%b oc2=%b want 100 1", rd[1], rd[2], rd[3], oc[2]);
    end
    checks++;
    if (pr[3] !== 1'b1 || oc[3] !== 1'b0) begin
      errors++; $display("FAIL held_iniciar_fim got pronto=%b ocupado=%b want 1 0", pr[3], oc[3]);
    end
    @(negedge clock);
    iniciar = 1'b0;
    checks++;
    if (memRead !== 1'b1) begin
      errors++; $display("FAIL second_accept got memRead=%b want 1", memRead);
    end
    for (int c = 5; c <= 10; c++) begin
      @(negedge clock);
      if (pronto) begin fim2 = c; break; end
    end
    checks++;
    if (fim2 !== 6 || dadoLoad !== 32'hFFFF_FFAA) begin
      errors++; $display("FAIL second_done got cyc=%0d data=%h want 6 FFFFFFAA", fim2, dadoLoad);
    end
  endtask

  task automatic test_reset_meio;
    int ciclos, nrd, nwr, wr_vistos; logic err; logic [31:0] w;
    wr_vistos = 0;
    @(negedge clock);
    escrever = 1'b1; tamanho = 2'b00; comSinal = 1'b0; endereco = 32'h14; dadoStore = 32'h77;
    iniciar = 1'b1;
    @(posedge clock);
    #1 iniciar = 1'b0;
    @(negedge clock);
    checks++;
    if (memRead !== 1'b1) begin
      errors++; $display("FAIL mid_reset_ler got memRead=%b want 1", memRead);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    if (memWrite) wr_vistos++;
    checks++;
    if (ocupado !== 1'b0 || memRead !== 1'b0 || dadoLoad !== 32'h0) begin
      errors++; $display("FAIL mid_reset_idle got ocupado=%b memRead=%b load=%h want 0 0 0", ocupado, memRead, dadoLoad);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (memWrite) wr_vistos++;
    end
    checks++;
    if (wr_vistos !== 0) begin
      errors++; $display("FAIL mid_reset_nowrite got %0d writes want 0", wr_vistos);
    end
    requisitar(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, ciclos, err, nrd, nwr, w);
    checks++;
    if (dadoLoad !== 32'h8899_AA12) begin
      errors++; $display("FAIL mid_reset_mem got %h want 8899AA12", dadoLoad);
    end
  endtask

  initial begin
    test_reset;
    test_load_byte;
    test_load_half;
    test_store_byte;
    test_store_word;
    test_faults;
    test_alinhamento;
    test_concorrencia;
    test_reset_meio;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
